// File: rtl/spiral_mcm_pipe.sv
// Two-stage shift-add multiple-constant multiplier for the HEVC partial butterflies.
// Stage 1 holds the shared odd partials (x1, x3, x5, x9); stage 2 holds the eight lane sums.
module spiral_mcm_pipe #(
    parameter int IN_W  = 19,
    parameter int OUT_W = IN_W + 7,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [IN_W-1:0]      i_data,
    input  logic [1:0]           i_mode,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [8*OUT_W-1:0]   o_data,
    output logic [1:0]           o_mode,
    output logic [TAG_W-1:0]     o_tag
);
    localparam int EXT_W = OUT_W - IN_W;

    logic               w_en;
    logic [OUT_W-1:0]   w_x1;
    logic [OUT_W-1:0]   w_x3;
    logic [OUT_W-1:0]   w_x5;
    logic [OUT_W-1:0]   w_x9;
    logic [OUT_W-1:0]   w_lane [8];
    logic [8*OUT_W-1:0] w_sum;

    logic               r_s1_valid;
    logic [1:0]         r_s1_mode;
    logic [TAG_W-1:0]   r_s1_tag;
    logic [OUT_W-1:0]   r_x1;
    logic [OUT_W-1:0]   r_x3;
    logic [OUT_W-1:0]   r_x5;
    logic [OUT_W-1:0]   r_x9;

    logic               r_o_valid;
    logic [1:0]         r_o_mode;
    logic [TAG_W-1:0]   r_o_tag;
    logic [8*OUT_W-1:0] r_o_data;

    // Valid/ready: a beat moves across a port on any cycle where both valid and ready
    // are high; valid must hold with stable data until then. One enable stalls both stages.
    assign w_en    = ~r_o_valid | i_ready;
    assign o_ready = w_en | rst;

    // Widen before shifting so every partial and lane sum is exact in OUT_W bits.
    assign w_x1 = {{EXT_W{i_data[IN_W-1]}}, i_data};
    assign w_x3 = (w_x1 << 1) + w_x1;
    assign w_x5 = (w_x1 << 2) + w_x1;
    assign w_x9 = (w_x1 << 3) + w_x1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 2'd0;
            r_s1_tag   <= '0;
            r_x1       <= '0;
            r_x3       <= '0;
            r_x5       <= '0;
            r_x9       <= '0;
        end else if (w_en) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_mode <= i_mode;
                r_s1_tag  <= i_tag;
                r_x1      <= w_x1;
                r_x3      <= w_x3;
                r_x5      <= w_x5;
                r_x9      <= w_x9;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_lane[k] = '0;
        end
        case (r_s1_mode)
            2'd0: begin
                w_lane[0] = r_x1 << 6;                   // 64
                w_lane[1] = (r_x5 << 4) + r_x3;          // 83
                w_lane[2] = r_x9 << 2;                   // 36
            end
            2'd1: begin
                w_lane[0] = (r_x5 << 4) + r_x9;          // 89
                w_lane[1] = (r_x9 << 3) + r_x3;          // 75
                w_lane[2] = (r_x3 << 4) + (r_x1 << 1);   // 50
                w_lane[3] = r_x9 << 1;                   // 18
            end
            2'd2: begin
                w_lane[0] = (r_x5 << 4) + (r_x5 << 1);   // 90
                w_lane[1] = (r_x3 << 5) - r_x9;          // 87
                w_lane[2] = r_x5 << 4;                   // 80
                w_lane[3] = (r_x5 << 4) - (r_x5 << 1);   // 70
                w_lane[4] = (r_x3 << 4) + r_x9;          // 57
                w_lane[5] = (r_x5 << 3) + r_x3;          // 43
                w_lane[6] = (r_x5 << 2) + r_x5;          // 25
                w_lane[7] = r_x9;                        // 9
            end
            default: ;
        endcase
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 8; k++) begin
            w_sum[k*OUT_W +: OUT_W] = w_lane[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_o_mode  <= 2'd0;
            r_o_tag   <= '0;
            r_o_data  <= '0;
        end else if (w_en) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_o_mode <= r_s1_mode;
                r_o_tag  <= r_s1_tag;
                r_o_data <= w_sum;
            end
        end
    end

    assign o_valid = r_o_valid;
    assign o_mode  = r_o_mode;
    assign o_tag   = r_o_tag;
    assign o_data  = r_o_data;
endmodule

// File: tb/tb_spiral_mcm_pipe.sv
// Directed and randomised checks of spiral_mcm_pipe against a coefficient-table model.
module tb_spiral_mcm_pipe;
    localparam int IN_W  = 19;
    localparam int OUT_W = 26;
    localparam int TAG_W = 8;
    localparam int EXP_W = 2 + TAG_W + 8 * OUT_W;

    logic               clk;
    logic               rst;
    logic               i_valid;
    logic               o_ready;
    logic [IN_W-1:0]    i_data;
    logic [1:0]         i_mode;
    logic [TAG_W-1:0]   i_tag;
    logic               o_valid;
    logic               i_ready;
    logic [8*OUT_W-1:0] o_data;
    logic [1:0]         o_mode;
    logic [TAG_W-1:0]   o_tag;

    spiral_mcm_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_mode(i_mode), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_mode(o_mode), .o_tag(o_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int coef [4][8] = '{
        '{64, 83, 36,  0,  0,  0,  0, 0},
        '{89, 75, 50, 18,  0,  0,  0, 0},
        '{90, 87, 80, 70, 57, 43, 25, 9},
        '{ 0,  0,  0,  0,  0,  0,  0, 0}
    };
    int ev [8];
    int exp4 [4][8] = '{
        '{-448, -581, -252,    0,    0,    0,    0,   0},
        '{-623, -525, -350, -126,    0,    0,    0,   0},
        '{-630, -609, -560, -490, -399, -301, -175, -63},
        '{   0,    0,    0,    0,    0,    0,    0,   0}
    };
    logic [EXP_W-1:0] exp_q [$];

    function automatic int lane(input int k);
        return int'($signed(o_data[k*OUT_W +: OUT_W]));
    endfunction

    function automatic logic [EXP_W-1:0] model(input int m, input int d, input int t);
        logic [8*OUT_W-1:0] v;
        int p;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            p = d * coef[m][k];
            v[k*OUT_W +: OUT_W] = p[OUT_W-1:0];
        end
        return {m[1:0], t[TAG_W-1:0], v};
    endfunction

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [EXP_W-1:0] obs, input logic [EXP_W-1:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_lanes(input string tag, input int e [8]);
        for (int k = 0; k < 8; k++) begin
            chk_int($sformatf("%s_lane%0d", tag, k), lane(k), e[k]);
        end
    endtask

    task automatic chk_beat(input string tag, input int m, input int d, input int t);
        chk_int({tag, "_valid"}, int'(o_valid), 1);
        chk_vec(tag, {o_mode, o_tag, o_data}, model(m, d, t));
    endtask

    task automatic drive(input logic v, input int m, input int d, input int t);
        i_valid = v;
        i_mode  = m[1:0];
        i_data  = d[IN_W-1:0];
        i_tag   = t[TAG_W-1:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic pend;
    int   pm, pd, pt, n_in, n_out, cyc;
    logic [EXP_W-1:0] e;

    initial begin
        rst = 1'b1;
        i_ready = 1'b0;
        drive(1'b0, 0, 0, 0);
        step();
        step();
        chk_int("rst_ready_during", int'(o_ready), 1);
        chk_int("rst_valid_during", int'(o_valid), 0);
        rst = 1'b0;
        step();
        chk_int("idle_valid", int'(o_valid), 0);
        chk_vec("idle_data", {o_mode, o_tag, o_data}, '0);
        chk_int("idle_ready", int'(o_ready), 1);

        // Single beat, mode 1, unit sample: two-cycle latency.
        i_ready = 1'b1;
        drive(1'b1, 1, 1, 8'h5A);
        step();
        drive(1'b0, 0, 0, 0);
        chk_int("m1_early_valid", int'(o_valid), 0);
        step();
        chk_int("m1_valid", int'(o_valid), 1);
        chk_int("m1_tag", int'(o_tag), 8'h5A);
        chk_int("m1_mode", int'(o_mode), 1);
        ev = '{89, 75, 50, 18, 0, 0, 0, 0};
        chk_lanes("m1", ev);
        step();
        chk_int("m1_after_valid", int'(o_valid), 0);

        // Most negative 19-bit sample through the widest set.
        drive(1'b1, 2, -262144, 8'hC3);
        step();
        drive(1'b0, 0, 0, 0);
        step();
        chk_int("min_valid", int'(o_valid), 1);
        ev = '{-23592960, -22806528, -20971520, -18350080, -14942208, -11272192, -6553600, -2359296};
        chk_lanes("min", ev);

        // Back-to-back mode changes with sample -7.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, i, -7, 10 + i);
            else       drive(1'b0, 0, 0, 0);
            step();
            if (i >= 1) begin
                chk_int($sformatf("stream%0d_valid", i - 1), int'(o_valid), 1);
                chk_int($sformatf("stream%0d_mode", i - 1), int'(o_mode), i - 1);
                chk_int($sformatf("stream%0d_tag", i - 1), int'(o_tag), 10 + i - 1);
                ev = exp4[i-1];
                chk_lanes($sformatf("stream%0d", i - 1), ev);
            end
        end
        step();

        // Stall with two beats in flight and a third offered.
        drive(1'b1, 2, 3, 1);
        step();
        drive(1'b1, 1, -5, 2);
        step();
        i_ready = 1'b0;
        drive(1'b1, 0, 11, 3);
        for (int c = 0; c < 3; c++) begin
            #3;
            chk_int($sformatf("stall%0d_ready", c), int'(o_ready), 0);
            chk_beat($sformatf("stall%0d_hold", c), 2, 3, 1);
            step();
        end
        i_ready = 1'b1;
        #3;
        chk_int("unstall_ready", int'(o_ready), 1);
        step();
        drive(1'b0, 0, 0, 0);
        chk_beat("unstall_b", 1, -5, 2);
        step();
        chk_beat("unstall_c", 0, 11, 3);
        step();
        chk_int("unstall_empty", int'(o_valid), 0);

        // Reset mid-stream while the output is stalled.
        drive(1'b1, 1, 7, 9);
        step();
        drive(1'b1, 2, 8, 10);
        step();
        i_ready = 1'b0;
        rst = 1'b1;
        drive(1'b1, 0, 5, 11);
        #3;
        chk_int("midrst_ready", int'(o_ready), 1);
        step();
        chk_int("midrst_valid", int'(o_valid), 0);
        chk_vec("midrst_data", {o_mode, o_tag, o_data}, '0);
        rst = 1'b0;
        i_ready = 1'b1;
        drive(1'b0, 0, 0, 0);
        step();
        chk_int("midrst_flush1", int'(o_valid), 0);
        step();
        chk_int("midrst_flush2", int'(o_valid), 0);

        // Random traffic with a held-until-accepted upstream and a bursty sink.
        pend = 1'b0;
        n_in = 0;
        n_out = 0;
        cyc = 0;
        pm = 0; pd = 0; pt = 0;
        while ((n_in < 2000 || exp_q.size() != 0) && cyc < 8000) begin
            if (!pend && n_in < 2000 && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pm = int'($urandom_range(0, 3));
                pd = int'($urandom_range(0, 524287)) - 262144;
                pt = int'($urandom_range(0, 255));
            end
            if (pend) drive(1'b1, pm, pd, pt);
            else      drive(1'b0, 0, 0, 0);
            i_ready = ($urandom_range(0, 3) != 0) || (n_in >= 2000);
            #3;
            if (o_valid && i_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL rnd_extra: observed beat %0h expected none", {o_mode, o_tag, o_data});
                end else begin
                    e = exp_q.pop_front();
                    chk_vec("rnd_beat", {o_mode, o_tag, o_data}, e);
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(pm, pd, pt));
                n_in++;
                pend = 1'b0;
            end
            step();
            cyc++;
        end
        chk_int("rnd_in_count", n_in, 2000);
        chk_int("rnd_out_count", n_out, n_in);
        chk_int("rnd_queue_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
